// File: rtl/if_stage_if.sv
// ============================================================================
// Module   : if_stage_if
// Brief    : Fetch-stage bus. It carries the instruction memory port, the
//            redirect request and the IF/ID slot handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_pc, id_valid, id_pc, id_inst, id_pc_plus4, fetch_fault, fault_pc,
    input  imem_inst, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_pc, id_valid, id_pc, id_inst, id_pc_plus4, fetch_fault, fault_pc,
    output imem_inst, redirect_valid, redirect_pc, id_ready
  );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction-fetch stage. It owns the PC and fills the IF/ID slot
//            under backpressure. It also handles redirects and halts on an
//            illegal fetch address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'd24,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  wire logic   clk,
  input  wire logic   rst,
  if_stage_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [31:0] c_pc_step = 32'd4;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc_plus4;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  logic        w_slot_free;
  logic        w_legal;
  logic        w_fetch;
  logic        w_fault;

  assign w_slot_free = !r_valid || bus.id_ready;
  assign w_legal     = (r_pc[1:0] == 2'b00) && (r_pc < ADDR_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.redirect_valid) begin
      w_next_state = S_RUN;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_RUN;
        S_RUN:   if (w_slot_free && !w_legal) w_next_state = S_HALT;
        S_HALT:  w_next_state = S_HALT;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // A redirect suppresses any fetch or fault decision in the same cycle.
  always_comb begin
    w_fetch = 1'b0;
    w_fault = 1'b0;
    if (!bus.redirect_valid && (r_state == S_RUN) && w_slot_free) begin
      w_fetch = w_legal;
      w_fault = !w_legal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_valid       <= 1'b0;
      r_id_pc       <= 32'd0;
      r_id_inst     <= NOP_INST;
      r_id_pc_plus4 <= 32'd0;
      r_fault       <= 1'b0;
      r_fault_pc    <= 32'd0;
    end else if (bus.redirect_valid) begin
      r_pc      <= bus.redirect_pc;
      r_valid   <= 1'b0;
      r_id_inst <= NOP_INST;
      r_fault   <= 1'b0;
    end else if (w_fault) begin
      r_fault    <= 1'b1;
      r_fault_pc <= r_pc;
      r_valid    <= 1'b0;
    end else if (w_fetch) begin
      r_valid       <= 1'b1;
      r_id_pc       <= r_pc;
      r_id_inst     <= bus.imem_inst;
      r_id_pc_plus4 <= r_pc + c_pc_step;
      r_pc          <= r_pc + c_pc_step;
    end else if (bus.id_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.imem_pc     = r_pc;
  assign bus.id_valid    = r_valid;
  assign bus.id_pc       = r_id_pc;
  assign bus.id_inst     = r_id_inst;
  assign bus.id_pc_plus4 = r_id_pc_plus4;
  assign bus.fetch_fault = r_fault;
  assign bus.fault_pc    = r_fault_pc;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage. It runs directed scenarios and
//            then random traffic against a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  if_stage_if bus ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'd0:   mem = 32'h00E6_0433;
      32'd4:   mem = 32'h40B6_0533;
      32'd8:   mem = 32'hFCE0_8793;
      32'd12:  mem = 32'h0081_2703;
      32'd16:  mem = 32'h00A0_0093;
      32'd20:  mem = 32'h0010_0113;
      default: mem = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign bus.imem_inst = mem(bus.imem_pc);

  // Behavioural model: the PC marches by 4 and the slot is refilled whenever
  // the decoder has room. A bad address stops fetching until a redirect.
  logic [31:0] m_pc, m_id_pc, m_inst, m_fault_pc;
  logic        m_valid, m_fault, m_started, m_halted, m_nop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'd0; m_valid <= 1'b0; m_id_pc <= 32'd0; m_inst <= NOP;
      m_fault <= 1'b0; m_fault_pc <= 32'd0; m_started <= 1'b0;
      m_halted <= 1'b0; m_nop <= 1'b1;
    end else if (bus.redirect_valid) begin
      m_pc <= bus.redirect_pc; m_valid <= 1'b0; m_inst <= NOP; m_nop <= 1'b1;
      m_fault <= 1'b0; m_halted <= 1'b0; m_started <= 1'b1;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!m_halted) begin
      if (!m_valid || bus.id_ready) begin
        if (m_pc[1:0] == 2'b00 && m_pc < 32'd24) begin
          m_valid <= 1'b1; m_id_pc <= m_pc; m_inst <= mem(m_pc);
          m_nop <= 1'b0; m_pc <= m_pc + 32'd4;
        end else begin
          m_fault <= 1'b1; m_fault_pc <= m_pc; m_halted <= 1'b1; m_valid <= 1'b0;
        end
      end
    end else if (bus.id_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_pc", bus.imem_pc, m_pc);
      chk("id_valid", {31'd0, bus.id_valid}, {31'd0, m_valid});
      chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
      chk("fault_pc", bus.fault_pc, m_fault_pc);
      if (m_valid) begin
        chk("id_pc", bus.id_pc, m_id_pc);
        chk("id_pc_plus4", bus.id_pc_plus4, m_id_pc + 32'd4);
      end
      if (m_valid || m_nop) chk("id_inst", bus.id_inst, m_inst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string name, input logic [31:0] pc, input logic [31:0] inst);
    chk({name, "_valid"}, {31'd0, bus.id_valid}, 32'd1);
    chk({name, "_pc"}, bus.id_pc, pc);
    chk({name, "_inst"}, bus.id_inst, inst);
    chk({name, "_plus4"}, bus.id_pc_plus4, pc + 32'd4);
  endtask

  initial begin
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_inst", bus.id_inst, NOP);
    chk("rst_pc", bus.imem_pc, 32'd0);
    chk("rst_idpc", bus.id_pc, 32'd0);
    chk("rst_plus4", bus.id_pc_plus4, 32'd0);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    tick();
    chk("idle_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("idle_pc", bus.imem_pc, 32'd0);
    tick(); slot("seq0", 32'd0, 32'h00E6_0433);
    tick(); slot("seq4", 32'd4, 32'h40B6_0533);
    tick(); slot("seq8", 32'd8, 32'hFCE0_8793);
    chk("seq8_imem", bus.imem_pc, 32'd12);
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); slot("stall", 32'd8, 32'hFCE0_8793);
      chk("stall_imem", bus.imem_pc, 32'd12);
    end
    bus.id_ready = 1'b1;
    tick(); slot("rel12", 32'd12, 32'h0081_2703);
    tick(); slot("seq16", 32'd16, 32'h00A0_0093);
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd4;
    tick();
    chk("flush_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("flush_inst", bus.id_inst, NOP);
    chk("flush_imem", bus.imem_pc, 32'd4);
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    tick(); slot("redir4", 32'd4, 32'h40B6_0533);
    for (int i = 0; i < 4; i++) tick();
    slot("seq20", 32'd20, 32'h0010_0113);
    chk("pc24", bus.imem_pc, 32'd24);
    tick();
    chk("fault_set", {31'd0, bus.fetch_fault}, 32'd1);
    chk("fault_pc24", bus.fault_pc, 32'h18);
    chk("fault_valid", {31'd0, bus.id_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_imem", bus.imem_pc, 32'h18);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd6;
    tick();
    chk("redir6_clr", {31'd0, bus.fetch_fault}, 32'd0);
    bus.redirect_valid = 1'b0;
    tick();
    chk("fault6", {31'd0, bus.fetch_fault}, 32'd1);
    chk("fault_pc6", bus.fault_pc, 32'd6);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd0;
    tick();
    chk("redir0_clr", {31'd0, bus.fetch_fault}, 32'd0);
    bus.redirect_valid = 1'b0;
    tick(); slot("redir0", 32'd0, 32'h00E6_0433);
    bus.id_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("async_imem", bus.imem_pc, 32'd0);
    tick();
    rst = 1'b0;
    bus.id_ready = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      bus.id_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0: bus.redirect_pc = 32'd4 * $urandom_range(0, 5);
        1: bus.redirect_pc = 32'd24 + 32'd4 * $urandom_range(0, 3);
        2: bus.redirect_pc = $urandom_range(0, 23);
        default: bus.redirect_pc = $urandom;
      endcase
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
